// File: rtl/mux4to1_arbiter_pkg.sv
// mux4to1_arbiter_pkg: shared state encodings, requester count and one-hot helper
package mux4to1_arbiter_pkg;
  localparam int ARB_N = 4;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  function automatic logic [ARB_N-1:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/mux4to1_arbiter_rr_pick.sv
// mux4to1_arbiter_rr_pick: combinational round-robin search from start, skipping excluded requesters
module mux4to1_arbiter_rr_pick
  import mux4to1_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       start,
  input  logic [ARB_N-1:0] excl,
  output logic             found,
  output logic [1:0]       idx
);
  logic [ARB_N-1:0] m;
  assign m = req & ~excl;
  always_comb begin
    found = 1'b0;
    idx = start;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (m[start + 2'(i)]) begin
        found = 1'b1;
        idx = start + 2'(i);
      end
    end
  end
endmodule

// File: rtl/mux4to1_arbiter.sv
// mux4to1_arbiter: round-robin one-hot select driver for mux4to1 with bounded hold time
module mux4to1_arbiter
  import mux4to1_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       busy,
  output logic [1:0] owner,
  output logic       expire
);
  localparam int HW = $clog2(MAX_HOLD);
  arb_state_t state, state_n;
  logic [1:0] last, last_n, owner_n, idx;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0] sel, sel_n;
  logic found, at_lim, rel, grant, expire_n;
  mux4to1_arbiter_rr_pick u_pick (
    .req   (req),
    .start (last + 2'd1),
    .excl  (state == ARB_GRANT ? oh(owner) : 4'b0000),
    .found (found),
    .idx   (idx)
  );
  always_comb begin
    at_lim = hold_cnt == HW'(MAX_HOLD - 1);
    rel = state == ARB_IDLE || done[owner] || !req[owner] || (at_lim && found);
    grant = rel && found;
    state_n = grant ? ARB_GRANT : rel ? ARB_IDLE : state;
    owner_n = grant ? idx : owner;
    last_n = grant ? idx : last;
    hold_n = grant ? '0 : (rel || at_lim) ? hold_cnt : hold_cnt + 1'b1;
    sel_n = grant ? oh(idx) : rel ? 4'b0000 : sel;
    expire_n = state == ARB_GRANT && at_lim && found && req[owner] && !done[owner];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ARB_IDLE;
      last <= 2'd3;
      owner <= 2'd0;
      hold_cnt <= '0;
      sel <= 4'b0000;
      busy <= 1'b0;
      expire <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      owner <= owner_n;
      hold_cnt <= hold_n;
      sel <= sel_n;
      busy <= state_n == ARB_GRANT;
      expire <= expire_n;
    end
  end
  assign {sel3, sel2, sel1, sel0} = sel;
endmodule
